// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared stage indices and per-stage record type for the pipeline controller
package riscv_pipe_pkg;

    localparam int IF_S = 0;
    localparam int ID_S = 1;
    localparam int EX_S = 2;

    // Register address field width held in a stage record; covers REGN up to 256.
    localparam int RDW = 8;

    localparam int FWD_RF = 0;

    typedef struct packed {
        logic           valid;
        logic [RDW-1:0] rd;
        logic           wr;
        logic           load;
        logic           mem;
    } pipe_rec_t;

endpackage

// File: rtl/riscv_hazard_detect.sv
// rtl/riscv_hazard_detect.sv - combinational load-use detection and forwarding-source selection
//
// Ports:
//   rec          in  stage records for EX..WB
//   id_valid     in  ID stage holds a valid instruction
//   id_rs1/2     in  ID source registers, id_use_rs1/2 mark which are read
//   lu           out load-use hazard against a load still ahead of MA
//   fwd_a/fwd_b  out 0 = register file, d = take the result from stage ID+d
module riscv_hazard_detect
    import riscv_pipe_pkg::*;
#(
    parameter int STAGES    = 5,
    parameter int MEM_STAGE = 3,
    parameter int REGA      = 5,
    parameter int FSW       = $clog2(STAGES-1)
) (
    input  pipe_rec_t        rec [EX_S:STAGES-1],
    input  logic             id_valid,
    input  logic [REGA-1:0]  id_rs1,
    input  logic [REGA-1:0]  id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    output logic             lu,
    output logic [FSW-1:0]   fwd_a,
    output logic [FSW-1:0]   fwd_b
);

    logic [RDW-1:0] rs1_x;
    logic [RDW-1:0] rs2_x;
    logic           chk1;
    logic           chk2;
    logic           lu_raw;
    logic           unused_rec;

    // x0 is hardwired, so it never hazards and never forwards.
    assign rs1_x = RDW'(id_rs1);
    assign rs2_x = RDW'(id_rs2);
    assign chk1  = id_use_rs1 && (id_rs1 != '0);
    assign chk2  = id_use_rs2 && (id_rs2 != '0);

    always_comb begin
        lu_raw = 1'b0;
        for (int k = EX_S; k < MEM_STAGE; k++) begin
            if (rec[k].valid && rec[k].load && rec[k].wr) begin
                if (chk1 && rec[k].rd == rs1_x) lu_raw = 1'b1;
                if (chk2 && rec[k].rd == rs2_x) lu_raw = 1'b1;
            end
        end
    end

    assign lu = lu_raw && id_valid;

    // Walk from the oldest candidate to the youngest so the nearest writer wins.
    always_comb begin
        fwd_a = FSW'(FWD_RF);
        fwd_b = FSW'(FWD_RF);
        for (int d = STAGES-2; d >= 1; d--) begin
            if (rec[1+d].valid && rec[1+d].wr) begin
                if (chk1 && rec[1+d].rd == rs1_x) fwd_a = FSW'(d);
                if (chk2 && rec[1+d].rd == rs2_x) fwd_b = FSW'(d);
            end
        end
    end

    always_comb begin
        unused_rec = 1'b0;
        for (int k = EX_S; k < STAGES; k++) unused_rec = unused_rec ^ rec[k].mem ^ rec[k].load;
    end

endmodule

// File: rtl/riscv_pipe_ctrl.sv
// rtl/riscv_pipe_ctrl.sv - pipeline valid/scoreboard tracking with stall, bubble, flush and forwarding control
//
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   id_*                   decode-stage instruction attributes
//   ex_redirect            taken branch/jump resolved in EX
//   mem_ready              MA access completes this cycle
//   stage_valid            per-stage valid bits
//   pc_hold                hold PC and the ID instruction
//   fwd_a, fwd_b           operand forwarding source for ID
//   mem_req                MA holds a valid memory access
//   wb_en, wb_rd           register-file write port
//   retire_count           cycles with a valid WB instruction
//   stall_count            cycles with pc_hold asserted
module riscv_pipe_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int REGN      = 32,
    parameter int STAGES    = 5,
    parameter int MEM_STAGE = 3,
    parameter int CNTW      = 32,
    localparam int REGA     = $clog2(REGN),
    localparam int FSW      = $clog2(STAGES-1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REGA-1:0]   id_rs1,
    input  logic [REGA-1:0]   id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REGA-1:0]   id_rd,
    input  logic              id_wr,
    input  logic              id_load,
    input  logic              id_mem,
    input  logic              ex_redirect,
    input  logic              mem_ready,
    output logic [STAGES-1:0] stage_valid,
    output logic              pc_hold,
    output logic [FSW-1:0]    fwd_a,
    output logic [FSW-1:0]    fwd_b,
    output logic              mem_req,
    output logic              wb_en,
    output logic [REGA-1:0]   wb_rd,
    output logic [CNTW-1:0]   retire_count,
    output logic [CNTW-1:0]   stall_count
);

    localparam int WB_S = STAGES - 1;

    logic      if_v;
    logic      id_v;
    pipe_rec_t rec [EX_S:STAGES-1];
    pipe_rec_t id_rec;
    logic      lu;
    logic      ms;
    logic      redirect;

    riscv_hazard_detect #(
        .STAGES    (STAGES),
        .MEM_STAGE (MEM_STAGE),
        .REGA      (REGA),
        .FSW       (FSW)
    ) u_hazard (
        .rec        (rec),
        .id_valid   (id_v),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .lu         (lu),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b)
    );

    // Invalid ID slots enter EX as all-zero bubbles so no stale rd can match.
    assign id_rec   = id_v ? '{valid: 1'b1, rd: RDW'(id_rd), wr: id_wr, load: id_load, mem: id_mem}
                           : '0;
    assign mem_req  = rec[MEM_STAGE].valid && rec[MEM_STAGE].mem;
    assign ms       = mem_req && !mem_ready;
    // EX is frozen during a memory stall, so the redirect is taken once the stall clears.
    assign redirect = ex_redirect && rec[EX_S].valid && !ms;
    // A redirect squashes the dependent ID instruction, so its hazard no longer matters.
    assign pc_hold  = ms || (lu && !redirect);
    assign wb_en    = rec[WB_S].valid && rec[WB_S].wr && (rec[WB_S].rd != '0);
    assign wb_rd    = rec[WB_S].rd[REGA-1:0];

    always_comb begin
        stage_valid       = '0;
        stage_valid[IF_S] = if_v;
        stage_valid[ID_S] = id_v;
        for (int k = EX_S; k < STAGES; k++) stage_valid[k] = rec[k].valid;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_v         <= 1'b0;
            id_v         <= 1'b0;
            retire_count <= '0;
            stall_count  <= '0;
            for (int k = EX_S; k < STAGES; k++) rec[k] <= '0;
        end else begin
            retire_count <= retire_count + CNTW'(rec[WB_S].valid);
            stall_count  <= stall_count + CNTW'(pc_hold);
            if (ms) begin
                // Everything up to MA waits; the stage after MA receives a bubble.
                rec[MEM_STAGE+1] <= '0;
                for (int k = MEM_STAGE+2; k < STAGES; k++) rec[k] <= rec[k-1];
            end else begin
                for (int k = EX_S+1; k < STAGES; k++) rec[k] <= rec[k-1];
                if (redirect) begin
                    if_v      <= 1'b1;
                    id_v      <= 1'b0;
                    rec[EX_S] <= '0;
                end else if (lu) begin
                    rec[EX_S] <= '0;
                end else begin
                    if_v      <= 1'b1;
                    id_v      <= if_v;
                    rec[EX_S] <= id_rec;
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// tb/tb_riscv_pipe_ctrl.sv - scoreboard bench for riscv_pipe_ctrl against an instruction-level pipeline model
module tb_riscv_pipe_ctrl;

    localparam int S    = 5;
    localparam int M    = 3;
    localparam int REGA = 5;
    localparam int FSW  = 2;
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [REGA-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_wr = 1'b0, id_load = 1'b0, id_mem = 1'b0;
    logic ex_redirect = 1'b0, mem_ready = 1'b1;

    logic [S-1:0] stage_valid, stage_valid4;
    logic pc_hold, pc_hold4, mem_req, mem_req4, wb_en, wb_en4;
    logic [FSW-1:0] fwd_a, fwd_b, fwd_a4, fwd_b4;
    logic [REGA-1:0] wb_rd, wb_rd4;
    logic [31:0] retire_count, stall_count;
    logic [3:0] retire_count4, stall_count4;

    always #5 clk = ~clk;

    riscv_pipe_ctrl #(.REGN(32), .STAGES(S), .MEM_STAGE(M), .CNTW(32)) dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load), .id_mem(id_mem),
        .ex_redirect(ex_redirect), .mem_ready(mem_ready), .stage_valid(stage_valid),
        .pc_hold(pc_hold), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_req(mem_req), .wb_en(wb_en),
        .wb_rd(wb_rd), .retire_count(retire_count), .stall_count(stall_count));

    riscv_pipe_ctrl #(.REGN(32), .STAGES(S), .MEM_STAGE(M), .CNTW(4)) dut4 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load), .id_mem(id_mem),
        .ex_redirect(ex_redirect), .mem_ready(mem_ready), .stage_valid(stage_valid4),
        .pc_hold(pc_hold4), .fwd_a(fwd_a4), .fwd_b(fwd_b4), .mem_req(mem_req4), .wb_en(wb_en4),
        .wb_rd(wb_rd4), .retire_count(retire_count4), .stall_count(stall_count4));

    typedef struct {
        logic [S-1:0]    sv;
        logic            hold;
        logic [FSW-1:0]  fa;
        logic [FSW-1:0]  fb;
        logic            mreq;
        logic            wben;
        logic [REGA-1:0] wbrd;
        longint          ret;
        longint          stl;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int failures = 0;

    // Model: which instruction occupies each stage, with its attributes.
    bit     mv[S];
    int     mrd[S];
    bit     mwr[S], mld[S], mmem[S];
    longint m_ret, m_stl;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < S; k++) begin
            mv[k] = 0; mrd[k] = 0; mwr[k] = 0; mld[k] = 0; mmem[k] = 0;
        end
        m_ret = 0;
        m_stl = 0;
    endtask

    function automatic bit src_hits_load(input int s, input bit use_s);
        if (!use_s || s == 0) return 0;
        for (int k = 2; k < M; k++)
            if (mv[k] && mld[k] && mwr[k] && mrd[k] == s) return 1;
        return 0;
    endfunction

    function automatic int fwd_of(input int s, input bit use_s);
        if (!use_s || s == 0) return 0;
        for (int d = 1; d <= S-2; d++)
            if (mv[1+d] && mwr[1+d] && mrd[1+d] == s) return d;
        return 0;
    endfunction

    task automatic decide(output bit lu, output bit ms, output bit red);
        lu  = mv[1] && (src_hits_load(int'(id_rs1), id_use_rs1) || src_hits_load(int'(id_rs2), id_use_rs2));
        ms  = mv[M] && mmem[M] && !mem_ready;
        red = ex_redirect && mv[2] && !ms;
    endtask

    // One clock: stages below the bubble point freeze, the bubble point empties,
    // everything above it moves one stage on.
    task automatic model_step();
        bit lu, ms, red;
        int f;
        bit ov[S]; int ord[S]; bit owr[S]; bit old[S]; bit omem[S];
        decide(lu, ms, red);
        m_ret += longint'(mv[S-1]);
        m_stl += longint'(ms || (lu && !red));
        ov = mv; ord = mrd; owr = mwr; old = mld; omem = mmem;
        f = ms ? M+1 : ((lu && !red) ? 2 : 0);
        for (int k = S-1; k >= 1; k--) begin
            if (k > f) begin
                if (k == 2) begin
                    mv[2] = ov[1]; mrd[2] = int'(id_rd); mwr[2] = id_wr; mld[2] = id_load; mmem[2] = id_mem;
                end else begin
                    mv[k] = ov[k-1]; mrd[k] = ord[k-1]; mwr[k] = owr[k-1]; mld[k] = old[k-1]; mmem[k] = omem[k-1];
                end
            end else if (k == f) begin
                mv[k] = 0; mrd[k] = 0; mwr[k] = 0; mld[k] = 0; mmem[k] = 0;
            end
        end
        if (f == 0) mv[0] = 1;
        if (red) begin
            mv[1] = 0;
            mv[2] = 0;
        end
    endtask

    task automatic make_exp(output exp_t e);
        bit lu, ms, red;
        decide(lu, ms, red);
        for (int k = 0; k < S; k++) e.sv[k] = mv[k];
        e.hold = ms || (lu && !red);
        e.fa   = FSW'(fwd_of(int'(id_rs1), id_use_rs1));
        e.fb   = FSW'(fwd_of(int'(id_rs2), id_use_rs2));
        e.mreq = mv[M] && mmem[M];
        e.wben = mv[S-1] && mwr[S-1] && (mrd[S-1] != 0);
        e.wbrd = REGA'(mrd[S-1]);
        e.ret  = m_ret;
        e.stl  = m_stl;
    endtask

    initial begin
        exp_t e;
        model_clear();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            if (rst) model_step(); else model_clear();
            if (cyc == 2) rst = 1'b1;
            else if (cyc > 20) begin
                if (!rst) rst = 1'b1;
                else if ($urandom_range(0, 149) == 0) rst = 1'b0;
            end
            if (!rst) model_clear();
            if (cyc < 20) begin
                id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
                id_rd = 5'd5; id_wr = 1; id_load = 0; id_mem = 0;
                ex_redirect = 0; mem_ready = 1;
            end else begin
                id_rs1      = REGA'($urandom_range(0, 7));
                id_rs2      = REGA'($urandom_range(0, 7));
                id_use_rs1  = ($urandom_range(0, 3) != 0);
                id_use_rs2  = ($urandom_range(0, 3) != 0);
                id_rd       = REGA'($urandom_range(0, 7));
                id_wr       = ($urandom_range(0, 3) != 0);
                id_load     = ($urandom_range(0, 9) < 3);
                id_mem      = id_load || ($urandom_range(0, 4) == 0);
                ex_redirect = ($urandom_range(0, 9) == 0);
                mem_ready   = ($urandom_range(0, 9) < 7);
            end
            make_exp(e);
            sbq.push_back(e);
        end
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("stage_valid", longint'(stage_valid), longint'(e.sv));
                chk("pc_hold", longint'(pc_hold), longint'(e.hold));
                chk("fwd_a", longint'(fwd_a), longint'(e.fa));
                chk("fwd_b", longint'(fwd_b), longint'(e.fb));
                chk("mem_req", longint'(mem_req), longint'(e.mreq));
                chk("wb_en", longint'(wb_en), longint'(e.wben));
                if (e.wben) chk("wb_rd", longint'(wb_rd), longint'(e.wbrd));
                chk("retire_count", longint'(retire_count), e.ret & 64'hFFFF_FFFF);
                chk("stall_count", longint'(stall_count), e.stl & 64'hFFFF_FFFF);
                chk("retire_count_w4", longint'(retire_count4), e.ret & 64'hF);
                chk("stall_count_w4", longint'(stall_count4), e.stl & 64'hF);
            end
        end
    end

endmodule
